// File: rtl/dest_check_arbiter_pkg.sv
// rtl/dest_check_arbiter_pkg.sv - shared constants and FSM encoding for the destination-check arbiter
package dest_check_arbiter_pkg;

    localparam int WORD_WIDTH             = 16;
    localparam int DEFAULT_TIMEOUT_CYCLES = 15;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

endpackage

// File: rtl/dest_check_arbiter_rr_pick.sv
// rtl/dest_check_arbiter_rr_pick.sv - combinational round-robin picker, first set bit at or after rr_ptr
module dest_check_arbiter_rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
    output logic [NUM_REQ-1:0]         winner_oh,
    output logic [$clog2(NUM_REQ)-1:0] winner_idx,
    output logic                       any_req
);
    import dest_check_arbiter_pkg::*;

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] cand;

    always_comb begin
        winner_oh  = '0;
        winner_idx = '0;
        any_req    = 1'b0;
        cand       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (!any_req && req[cand]) begin
                any_req         = 1'b1;
                winner_oh[cand] = 1'b1;
                winner_idx      = cand;
            end
        end
    end

endmodule

// File: rtl/dest_check_arbiter.sv
// rtl/dest_check_arbiter.sv - round-robin arbiter sequencing one shared destination-check unit
module dest_check_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int WORD_WIDTH     = dest_check_arbiter_pkg::WORD_WIDTH,
    parameter int TIMEOUT_CYCLES = dest_check_arbiter_pkg::DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                          clock,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*WORD_WIDTH-1:0] req_dest_id,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            resp_valid,
    output logic                          resp_is_dest,
    output logic                          resp_timeout,
    output logic                          busy,
    output logic                          unit_en,
    output logic                          unit_start,
    output logic [WORD_WIDTH-1:0]         unit_dest_id,
    input  logic                          unit_is_dest,
    input  logic                          unit_done
);
    import dest_check_arbiter_pkg::*;

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]      win_q, win_d;
    logic [WD_W-1:0]       wd_cnt_q, wd_cnt_d;
    logic [NUM_REQ-1:0]    gnt_q, gnt_d;
    logic [NUM_REQ-1:0]    resp_valid_q, resp_valid_d;
    logic                  resp_is_dest_q, resp_is_dest_d;
    logic                  resp_timeout_q, resp_timeout_d;
    logic                  busy_q, busy_d;
    logic                  unit_en_q, unit_en_d;
    logic                  unit_start_q, unit_start_d;
    logic [WORD_WIDTH-1:0] unit_dest_id_q, unit_dest_id_d;

    logic [NUM_REQ-1:0]    pick_oh;
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_any;
    logic [WORD_WIDTH-1:0] pick_id;

    dest_check_arbiter_rr_pick #(
        .NUM_REQ(NUM_REQ)
    ) u_rr_pick (
        .req       (req),
        .rr_ptr    (rr_ptr_q),
        .winner_oh (pick_oh),
        .winner_idx(pick_idx),
        .any_req   (pick_any)
    );

    always_comb begin
        pick_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_oh[i]) pick_id = req_dest_id[i*WORD_WIDTH +: WORD_WIDTH];
        end
    end

    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        win_d          = win_q;
        wd_cnt_d       = wd_cnt_q;
        gnt_d          = gnt_q;
        resp_valid_d   = '0;
        resp_is_dest_d = resp_is_dest_q;
        resp_timeout_d = resp_timeout_q;
        unit_en_d      = 1'b0;
        unit_start_d   = 1'b0;
        unit_dest_id_d = unit_dest_id_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    gnt_d          = pick_oh;
                    win_d          = pick_idx;
                    unit_dest_id_d = pick_id;
                    wd_cnt_d       = '0;
                    unit_en_d      = 1'b1;
                    state_d        = ST_ARM;
                end
            end
            ST_ARM: begin
                unit_start_d = 1'b1;
                state_d      = ST_START;
            end
            ST_START: state_d = ST_WAIT;
            ST_WAIT: begin
                // done wins over an expiring watchdog on the same edge
                if (unit_done) begin
                    resp_is_dest_d = unit_is_dest;
                    resp_timeout_d = 1'b0;
                    resp_valid_d   = gnt_q;
                    state_d        = ST_RESP;
                end else begin
                    wd_cnt_d = WD_W'(wd_cnt_q + 1'b1);
                    if (wd_cnt_d == WD_W'(TIMEOUT_CYCLES)) begin
                        resp_is_dest_d = 1'b0;
                        resp_timeout_d = 1'b1;
                        resp_valid_d   = gnt_q;
                        state_d        = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                gnt_d          = '0;
                resp_is_dest_d = 1'b0;
                resp_timeout_d = 1'b0;
                rr_ptr_d       = (int'(win_q) == NUM_REQ - 1) ? '0 : IDX_W'(win_q + 1'b1);
                state_d        = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            rr_ptr_q       <= '0;
            win_q          <= '0;
            wd_cnt_q       <= '0;
            gnt_q          <= '0;
            resp_valid_q   <= '0;
            resp_is_dest_q <= 1'b0;
            resp_timeout_q <= 1'b0;
            busy_q         <= 1'b0;
            unit_en_q      <= 1'b0;
            unit_start_q   <= 1'b0;
            unit_dest_id_q <= '0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            win_q          <= win_d;
            wd_cnt_q       <= wd_cnt_d;
            gnt_q          <= gnt_d;
            resp_valid_q   <= resp_valid_d;
            resp_is_dest_q <= resp_is_dest_d;
            resp_timeout_q <= resp_timeout_d;
            busy_q         <= busy_d;
            unit_en_q      <= unit_en_d;
            unit_start_q   <= unit_start_d;
            unit_dest_id_q <= unit_dest_id_d;
        end
    end

    assign gnt          = gnt_q;
    assign resp_valid   = resp_valid_q;
    assign resp_is_dest = resp_is_dest_q;
    assign resp_timeout = resp_timeout_q;
    assign busy         = busy_q;
    assign unit_en      = unit_en_q;
    assign unit_start   = unit_start_q;
    assign unit_dest_id = unit_dest_id_q;

endmodule

// File: tb/tb_dest_check_arbiter.sv
// tb/tb_dest_check_arbiter.sv - scoreboard bench for dest_check_arbiter with a behavioural check unit
module tb_dest_check_arbiter;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam logic [W-1:0] MY_NODE_ID = 16'h0005;

    logic             clock;
    logic             rst;
    logic [N-1:0]     req;
    logic [N*W-1:0]   req_dest_id;
    logic [N-1:0]     gnt;
    logic [N-1:0]     resp_valid;
    logic             resp_is_dest;
    logic             resp_timeout;
    logic             busy;
    logic             unit_en;
    logic             unit_start;
    logic [W-1:0]     unit_dest_id;
    logic             unit_is_dest;
    logic             unit_done;

    logic             stuck;
    logic [1:0]       sh;
    int               cyc;
    int               n_checks;
    int               n_fail;

    typedef struct {
        int   idx;
        logic is_dest;
        logic timeout;
        int   cyc;
    } exp_t;
    exp_t sb[$];

    dest_check_arbiter #(
        .NUM_REQ(N), .WORD_WIDTH(W), .TIMEOUT_CYCLES(15)
    ) dut (
        .clock(clock), .rst(rst), .req(req), .req_dest_id(req_dest_id),
        .gnt(gnt), .resp_valid(resp_valid), .resp_is_dest(resp_is_dest),
        .resp_timeout(resp_timeout), .busy(busy), .unit_en(unit_en),
        .unit_start(unit_start), .unit_dest_id(unit_dest_id),
        .unit_is_dest(unit_is_dest), .unit_done(unit_done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    // check unit: en clears it, done rises two edges after start is seen
    always @(posedge clock or posedge rst) begin
        if (rst) begin
            unit_done    <= 1'b0;
            unit_is_dest <= 1'b0;
            sh           <= 2'b00;
        end else if (unit_en) begin
            unit_done <= 1'b0;
            sh        <= 2'b00;
        end else begin
            sh <= {sh[0], unit_start};
            if (sh[1] && !stuck) begin
                unit_done    <= 1'b1;
                unit_is_dest <= (unit_dest_id == MY_NODE_ID);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (resp_valid != '0) begin
            if (sb.size() == 0) begin
                check("unexpected_resp", {28'd0, resp_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("resp_valid", {28'd0, resp_valid}, 32'd1 << e.idx);
                check("resp_is_dest", {31'd0, resp_is_dest}, {31'd0, e.is_dest});
                check("resp_timeout", {31'd0, resp_timeout}, {31'd0, e.timeout});
                check("resp_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic push(input int idx, input logic is_dest, input logic timeout, input int lat);
        exp_t e;
        e.idx = idx; e.is_dest = is_dest; e.timeout = timeout; e.cyc = cyc + lat;
        sb.push_back(e);
    endtask

    task automatic set_id(input int idx, input logic [W-1:0] id);
        req_dest_id[idx*W +: W] = id;
    endtask

    task automatic wait_resps(input string name, input int n, input int budget);
        int seen = 0;
        for (int c = 0; c < budget && seen < n; c++) begin
            @(negedge clock);
            if (resp_valid != '0) seen++;
        end
        check(name, seen, n);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_gnt"}, {28'd0, gnt}, 32'd0);
        check({tag, "_resp_valid"}, {28'd0, resp_valid}, 32'd0);
        check({tag, "_flags"}, {28'd0, resp_is_dest, resp_timeout, unit_en, unit_start}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_unit_dest_id"}, {16'd0, unit_dest_id}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        rst = 1'b1;
        req = '0;
        #1;
        check_idle_outputs("reset");
        @(negedge clock);
        rst = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        rst = 1'b1; req = '0; req_dest_id = '0; stuck = 1'b0;
        cyc = 0; n_checks = 0; n_fail = 0;
        repeat (2) @(negedge clock);
        check_idle_outputs("por");
        rst = 1'b0;
        @(negedge clock);

        // single request, match, with per-cycle handshake checks
        set_id(1, 16'h0005);
        req = 4'b0010;
        push(1, 1'b1, 1'b0, 6);
        @(negedge clock);
        check("single_gnt", {28'd0, gnt}, 32'b0010);
        check("single_en", {30'd0, unit_en, unit_start}, 32'b10);
        check("single_busy", {31'd0, busy}, 32'd1);
        check("single_dest_id", {16'd0, unit_dest_id}, 32'h0005);
        @(negedge clock);
        check("single_start", {30'd0, unit_en, unit_start}, 32'b01);
        wait_resps("wait_single", 1, 40);
        req = '0;
        @(negedge clock);
        check("single_idle_busy", {31'd0, busy}, 32'd0);
        check("single_idle_gnt", {28'd0, gnt}, 32'd0);

        // mismatching ID on requester 0
        set_id(0, 16'h0003);
        req = 4'b0001;
        push(0, 1'b0, 1'b0, 6);
        wait_resps("wait_mismatch", 1, 40);
        req = '0;
        @(negedge clock);

        // all four contending from reset: strict rotation 0,1,2,3,0
        do_reset();
        set_id(0, 16'h0005); set_id(1, 16'h0003); set_id(2, 16'h0005); set_id(3, 16'h0007);
        req = 4'b1111;
        push(0, 1'b1, 1'b0, 6);
        push(1, 1'b0, 1'b0, 13);
        push(2, 1'b1, 1'b0, 20);
        push(3, 1'b0, 1'b0, 27);
        push(0, 1'b1, 1'b0, 34);
        wait_resps("wait_rr", 5, 60);
        req = '0;
        @(negedge clock);

        // stuck unit hits the watchdog, then a normal service follows
        stuck = 1'b1;
        set_id(2, 16'h0005);
        req = 4'b0100;
        push(2, 1'b0, 1'b1, 18);
        wait_resps("wait_stuck", 1, 60);
        req = '0;
        stuck = 1'b0;
        @(negedge clock);
        set_id(3, 16'h0005);
        req = 4'b1000;
        push(3, 1'b1, 1'b0, 6);
        wait_resps("wait_after_stuck", 1, 40);
        req = '0;
        @(negedge clock);

        // reset while waiting on the unit
        stuck = 1'b1;
        set_id(1, 16'h0005);
        req = 4'b0010;
        repeat (4) @(negedge clock);
        check("pre_reset_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        req = '0;
        #1;
        check_idle_outputs("mid_reset");
        @(negedge clock);
        rst = 1'b0;
        stuck = 1'b0;
        repeat (3) @(negedge clock);
        check("post_reset_busy", {31'd0, busy}, 32'd0);
        set_id(2, 16'h0005);
        req = 4'b0100;
        push(2, 1'b1, 1'b0, 6);
        wait_resps("wait_post_reset", 1, 40);
        req = '0;
        @(negedge clock);

        // req and ID change during WAIT do not affect the latched service
        set_id(3, 16'h0005);
        req = 4'b1000;
        push(3, 1'b1, 1'b0, 6);
        repeat (4) @(negedge clock);
        req = '0;
        set_id(3, 16'h0003);
        wait_resps("wait_drop", 1, 40);
        repeat (3) @(negedge clock);

        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dest_check_arbiter.md
Name: dest_check_arbiter

Overview:
- Round-robin arbiter and sequencer sharing one destination-check unit (start/en/done handshake, 16-bit node IDs) among NUM_REQ requesters, e.g. the input ports of a routing node.
- Picks one requester and latches its destination ID.
- Drives the unit's en/start sequence, waits for done, and returns the is-destination result to the granted requester.
- A watchdog bounds the wait for done.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WORD_WIDTH, 16, node ID width.
- TIMEOUT_CYCLES, 15, maximum cycles spent in WAIT before abort (1..255).

Ports:
- clock  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester request level.
- req_dest_id  in  NUM_REQ*WORD_WIDTH  flattened destination IDs; requester i uses bits [i*W +: W].
- gnt  out  NUM_REQ  one-hot grant, held for the whole service.
- resp_valid  out  NUM_REQ  one-cycle response strobe, one-hot.
- resp_is_dest  out  1  result; valid only while any resp_valid bit is 1.
- resp_timeout  out  1  service aborted by the watchdog; valid with resp_valid.
- busy  out  1  high in every state except IDLE.
- unit_en  out  1  to check unit: clears/re-arms it.
- unit_start  out  1  to check unit: start compare.
- unit_dest_id  out  WORD_WIDTH  to check unit destinationID; stable from ARM through WAIT.
- unit_is_dest  in  1  from check unit iamDestination.
- unit_done  in  1  from check unit done (level, stays high until the next en).

Behaviour:
- Reset (async, rst=1): state=IDLE, rr_ptr=0. All outputs 0: gnt, resp_valid, resp_is_dest, resp_timeout, busy, unit_en, unit_start, unit_dest_id.
- All outputs are registered.
- FSM states: IDLE, ARM, START, WAIT, RESP.
- IDLE: if any req bit is set, select the first set bit at or after rr_ptr, searching upward with wrap.
  - Set gnt[winner] and latch req_dest_id[winner] into unit_dest_id.
  - Clear wd_cnt and go to ARM.
  - With no req, stay in IDLE.
- ARM: unit_en=1 for exactly one cycle, then START.
- START: unit_start=1 for exactly one cycle, then WAIT.
- unit_done is ignored in ARM and START, because a stale done from the previous service is cleared by the en pulse.
- WAIT: if unit_done=1, capture unit_is_dest, set resp_timeout=0, go to RESP.
  - Otherwise increment wd_cnt. When wd_cnt reaches TIMEOUT_CYCLES, set resp_is_dest=0 and resp_timeout=1, then go to RESP.
  - unit_done takes priority if both occur on the same edge.
- RESP: resp_valid[winner]=1 for one cycle, together with resp_is_dest and resp_timeout.
  - On exit: gnt=0, resp_valid=0, resp_is_dest=0, resp_timeout=0; rr_ptr=(winner+1) mod NUM_REQ; go to IDLE.
- Latency with a nominal unit (done 4 edges after en):
  - req sampled at edge 0.
  - gnt and unit_en visible after edge 0.
  - unit_start visible after edge 1.
  - unit_done visible after edge 4.
  - resp_valid visible after edge 5, for one cycle.
  - IDLE again after edge 6, so there is one service per 7 cycles minimum.
- Requester rule: keep req high until resp_valid.
  - If req drops during service, the service still completes and resp_valid still pulses.
  - req_dest_id is sampled only in IDLE, so later changes are ignored.
- Fairness:
  - A requester holding req is served within NUM_REQ services.
  - The requester just served is lowest priority on the next arbitration.
- Simultaneous requests: all contenders are resolved by rr_ptr order in a single IDLE cycle.
- Reset mid-service: immediate return to IDLE, no resp_valid emitted. The unit is re-armed by the next ARM, so no stale result leaks.
- rr_ptr width: clog2(NUM_REQ); wraps NUM_REQ-1 -> 0.
- wd_cnt width: clog2(TIMEOUT_CYCLES+1).

Decomposition:
- Shared package:
  - WORD_WIDTH constant.
  - FSM state encoding (IDLE=0, ARM=1, START=2, WAIT=3, RESP=4; 3 bits).
  - Default TIMEOUT_CYCLES.
- One sub-module, rr_pick: combinational round-robin priority picker.
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot winner, winner index, any_req.
  - Reused by later port arbiters.

Test Plan:
- Single request: req=4'b0010, req_dest_id[1]=16'h0005, unit model with MY_NODE_ID=16'h0005 -> gnt=4'b0010 after edge 0, unit_en at edge 1, unit_start at edge 2, resp_valid=4'b0010 with resp_is_dest=1, resp_timeout=0 exactly 6 cycles after req; busy low after edge 6.
- Mismatch: req[0], ID 16'h0003 vs MY_NODE_ID 16'h0005 -> resp_valid[0] with resp_is_dest=0.
- All four requesting continuously from reset -> grant order 0,1,2,3,0; no requester is served twice before the others are served once.
- Stuck unit (unit_done tied 0) -> resp_valid pulses after TIMEOUT_CYCLES=15 WAIT cycles with resp_timeout=1, resp_is_dest=0; the next request is then served normally.
- Assert rst during WAIT -> all outputs 0 asynchronously, rr_ptr=0, no resp_valid; a new req[2] after reset completes with correct latency.
- req[3] drops and req_dest_id[3] changes during WAIT -> resp_valid[3] still pulses; result reflects the ID latched in IDLE.
